bp_addr_gen_unit: RTL and testbench

//  Backprop-through-time address generator for one LSTM layer. It walks

---
 rtl/bp_addr_gen_unit.sv | 199 +++++++++++++++++++
 tb/tb_bp_addr_gen_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bp_addr_gen_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bp_addr_gen_unit
//  Description : Backprop-through-time address generator for one LSTM layer.
//                Walks timesteps in reverse (TIMESTEP-1 down to 0) and
//                produces three address groups:
//                  - delta phase : activation read / delta-gate write
//                  - dstate      : dstate read / write
//                  - dwu         : dgate / weight addresses for W^T*dgate
//  Ports       : clk, rst (sync, active low), en_delta, en_dwu
//                o_addr_aioht, o_addr_dgates, o_dstate_rd, o_dstate_wr,
//                o_addr_d, o_addr_w, o_delta_done, o_dwu_done
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_addr_gen_unit #(
    parameter int ADDR_WIDTH   = 12,
    parameter int NUM_CELL     = 8,
    parameter int NUM_INPUT    = 53,
    parameter int TIMESTEP     = 7,
    parameter int DELTA_TIME   = 12,
    parameter int DSTATE_DELAY = 12,
    parameter int DWU_DELAY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_delta,
    input  logic                  en_dwu,
    output logic [ADDR_WIDTH-1:0] o_addr_aioht,
    output logic [ADDR_WIDTH-1:0] o_addr_dgates,
    output logic [ADDR_WIDTH-1:0] o_dstate_rd,
    output logic [ADDR_WIDTH-1:0] o_dstate_wr,
    output logic [ADDR_WIDTH-1:0] o_addr_d,
    output logic [ADDR_WIDTH-1:0] o_addr_w,
    output logic                  o_delta_done,
    output logic                  o_dwu_done
);

    localparam int c_P_W = (DELTA_TIME > 1) ? $clog2(DELTA_TIME) : 1;
    localparam int c_N_W = (NUM_CELL   > 1) ? $clog2(NUM_CELL)   : 1;
    localparam int c_J_W = (NUM_INPUT  > 1) ? $clog2(NUM_INPUT)  : 1;
    localparam int c_T_W = (TIMESTEP   > 1) ? $clog2(TIMESTEP)   : 1;
    localparam int c_G_W = (DWU_DELAY  > 0) ? $clog2(DWU_DELAY + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_NC_A      = ADDR_WIDTH'(NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] c_NI_A      = ADDR_WIDTH'(NUM_INPUT);
    localparam logic [ADDR_WIDTH-1:0] c_TOP_ADDR  = ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELL);
    localparam logic [c_P_W-1:0]      c_P_LAST    = c_P_W'(DELTA_TIME - 1);
    localparam logic [c_N_W-1:0]      c_N_LAST    = c_N_W'(NUM_CELL - 1);
    localparam logic [c_J_W-1:0]      c_J_LAST    = c_J_W'(NUM_INPUT - 1);
    localparam logic [c_T_W-1:0]      c_T_LAST    = c_T_W'(TIMESTEP - 1);
    localparam logic [c_G_W-1:0]      c_G_LAST    = c_G_W'(DWU_DELAY);

    // ------------------------------------------------------------------
    // Delta section state
    // ------------------------------------------------------------------
    logic [c_P_W-1:0]      r_p;
    logic [c_N_W-1:0]      r_n;
    logic [c_T_W-1:0]      r_t;
    logic [ADDR_WIDTH-1:0] r_aioht;
    logic [ADDR_WIDTH-1:0] r_dstate_rd;
    logic                  r_delta_done;
    // Delay lines advance only on en_delta, so their lag is in enabled cycles
    logic [ADDR_WIDTH-1:0] r_dg_line [DELTA_TIME];
    logic [ADDR_WIDTH-1:0] r_ds_line [DSTATE_DELAY];

    logic [c_P_W-1:0]      w_p_nxt;
    logic [c_N_W-1:0]      w_n_nxt;
    logic [c_T_W-1:0]      w_t_nxt;
    logic                  w_delta_wrap;

    always_comb begin
        w_p_nxt      = r_p;
        w_n_nxt      = r_n;
        w_t_nxt      = r_t;
        w_delta_wrap = 1'b0;
        if (r_p == c_P_LAST) begin
            w_p_nxt = '0;
            if (r_n == c_N_LAST) begin
                w_n_nxt = '0;
                if (r_t == '0) begin
                    w_t_nxt      = c_T_LAST;
                    w_delta_wrap = 1'b1;
                end else begin
                    w_t_nxt = r_t - 1'b1;
                end
            end else begin
                w_n_nxt = r_n + 1'b1;
            end
        end else begin
            w_p_nxt = r_p + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p          <= '0;
            r_n          <= '0;
            r_t          <= c_T_LAST;
            r_aioht      <= c_TOP_ADDR;
            r_dstate_rd  <= '0;
            r_delta_done <= 1'b0;
            for (int i = 0; i < DELTA_TIME; i++)   r_dg_line[i] <= c_TOP_ADDR;
            for (int i = 0; i < DSTATE_DELAY; i++) r_ds_line[i] <= '0;
        end else begin
            r_delta_done <= en_delta & w_delta_wrap;
            if (en_delta) begin
                r_p         <= w_p_nxt;
                r_n         <= w_n_nxt;
                r_t         <= w_t_nxt;
                r_aioht     <= ADDR_WIDTH'(w_t_nxt) * c_NC_A + ADDR_WIDTH'(w_n_nxt);
                r_dstate_rd <= ADDR_WIDTH'(w_n_nxt);
                // Shift in the pre-update value so tap K holds the value K+1 edges old
                r_dg_line[0] <= r_aioht;
                for (int i = 1; i < DELTA_TIME; i++)   r_dg_line[i] <= r_dg_line[i-1];
                r_ds_line[0] <= r_dstate_rd;
                for (int i = 1; i < DSTATE_DELAY; i++) r_ds_line[i] <= r_ds_line[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // dwu section state
    // ------------------------------------------------------------------
    logic [c_N_W-1:0]      r_k;
    logic [c_J_W-1:0]      r_j;
    logic [c_T_W-1:0]      r_tw;
    logic [c_G_W-1:0]      r_g;
    logic [ADDR_WIDTH-1:0] r_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_w;
    logic                  r_dwu_done;

    logic [c_N_W-1:0]      w_k_nxt;
    logic [c_J_W-1:0]      w_j_nxt;
    logic [c_T_W-1:0]      w_tw_nxt;
    logic [c_G_W-1:0]      w_g_nxt;
    logic                  w_dwu_wrap;

    // Once k reaches the last cell, g counts the flush gap while k stays put,
    // so addresses hold at the last cell until the column advances.
    always_comb begin
        w_k_nxt    = r_k;
        w_j_nxt    = r_j;
        w_tw_nxt   = r_tw;
        w_g_nxt    = r_g;
        w_dwu_wrap = 1'b0;
        if (r_k != c_N_LAST) begin
            w_k_nxt = r_k + 1'b1;
        end else if (r_g != c_G_LAST) begin
            w_g_nxt = r_g + 1'b1;
        end else begin
            w_g_nxt = '0;
            w_k_nxt = '0;
            if (r_j == c_J_LAST) begin
                w_j_nxt = '0;
                if (r_tw == '0) begin
                    w_tw_nxt   = c_T_LAST;
                    w_dwu_wrap = 1'b1;
                end else begin
                    w_tw_nxt = r_tw - 1'b1;
                end
            end else begin
                w_j_nxt = r_j + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k        <= '0;
            r_j        <= '0;
            r_tw       <= c_T_LAST;
            r_g        <= '0;
            r_addr_d   <= c_TOP_ADDR;
            r_addr_w   <= '0;
            r_dwu_done <= 1'b0;
        end else begin
            r_dwu_done <= en_dwu & w_dwu_wrap;
            if (en_dwu) begin
                r_k      <= w_k_nxt;
                r_j      <= w_j_nxt;
                r_tw     <= w_tw_nxt;
                r_g      <= w_g_nxt;
                r_addr_d <= ADDR_WIDTH'(w_tw_nxt) * c_NC_A + ADDR_WIDTH'(w_k_nxt);
                r_addr_w <= ADDR_WIDTH'(w_k_nxt) * c_NI_A + ADDR_WIDTH'(w_j_nxt);
            end
        end
    end

    assign o_addr_aioht  = r_aioht;
    assign o_addr_dgates = r_dg_line[DELTA_TIME-1];
    assign o_dstate_rd   = r_dstate_rd;
    assign o_dstate_wr   = r_ds_line[DSTATE_DELAY-1];
    assign o_addr_d      = r_addr_d;
    assign o_addr_w      = r_addr_w;
    assign o_delta_done  = r_delta_done;
    assign o_dwu_done    = r_dwu_done;

endmodule
`default_nettype wire

// File: tb/tb_bp_addr_gen_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_addr_gen_unit
//  Description : Self-checking bench for bp_addr_gen_unit (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_addr_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_delta = 1'b0;
    logic        en_dwu = 1'b0;
    logic [11:0] o_addr_aioht, o_addr_dgates, o_dstate_rd, o_dstate_wr;
    logic [11:0] o_addr_d, o_addr_w;
    logic        o_delta_done, o_dwu_done;

    bp_addr_gen_unit dut (
        .clk          (clk),
        .rst          (rst),
        .en_delta     (en_delta),
        .en_dwu       (en_dwu),
        .o_addr_aioht (o_addr_aioht),
        .o_addr_dgates(o_addr_dgates),
        .o_dstate_rd  (o_dstate_rd),
        .o_dstate_wr  (o_dstate_wr),
        .o_addr_d     (o_addr_d),
        .o_addr_w     (o_addr_w),
        .o_delta_done (o_delta_done),
        .o_dwu_done   (o_dwu_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] aioht, dgates, rd, wr, d, w;
        logic        ddone, wdone;
    } exp_t;

    typedef struct {
        logic ed;
        logic ew;
        int   n;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   delta_pulses = 0;
    int   dwu_pulses = 0;

    // Sampled before the edge's updates, so each high cycle counts once
    always @(posedge clk) begin
        if (o_delta_done) delta_pulses++;
        if (o_dwu_done)   dwu_pulses++;
    end

    function automatic exp_t mk(int a, int g, int r, int w, int d, int ww, int dd, int wd);
        exp_t e;
        e.aioht = 12'(a); e.dgates = 12'(g); e.rd = 12'(r); e.wr = 12'(w);
        e.d = 12'(d); e.w = 12'(ww); e.ddone = dd[0]; e.wdone = wd[0];
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        chk("aioht",      int'(o_addr_aioht),  int'(e.aioht));
        chk("dgates",     int'(o_addr_dgates), int'(e.dgates));
        chk("dstate_rd",  int'(o_dstate_rd),   int'(e.rd));
        chk("dstate_wr",  int'(o_dstate_wr),   int'(e.wr));
        chk("addr_d",     int'(o_addr_d),      int'(e.d));
        chk("addr_w",     int'(o_addr_w),      int'(e.w));
        chk("delta_done", int'(o_delta_done),  int'(e.ddone));
        chk("dwu_done",   int'(o_dwu_done),    int'(e.wdone));
    endtask

    // Advance n rising edges, then settle on the following falling edge
    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_check(input int n, input exp_t e);
        sb.push_back(e);
        run(n);
        sb_check();
    endtask

    vec_t vecs[9];

    initial begin
        // Cumulative from reset release: (delta edges, dwu edges) noted per row
        vecs[0] = '{1'b1, 1'b1,   7, mk(48, 48, 0, 0, 55, 371, 0, 0)}; // (7,7)
        vecs[1] = '{1'b1, 1'b1,   1, mk(48, 48, 0, 0, 55, 371, 0, 0)}; // (8,8) gap
        vecs[2] = '{1'b1, 1'b1,   1, mk(48, 48, 0, 0, 55, 371, 0, 0)}; // (9,9) gap
        vecs[3] = '{1'b1, 1'b1,   1, mk(48, 48, 0, 0, 48,   1, 0, 0)}; // (10,10)
        vecs[4] = '{1'b1, 1'b1,   2, mk(49, 48, 1, 0, 50, 107, 0, 0)}; // (12,12)
        vecs[5] = '{1'b0, 1'b0,   5, mk(49, 48, 1, 0, 50, 107, 0, 0)}; // frozen
        vecs[6] = '{1'b1, 1'b0,  12, mk(50, 49, 2, 1, 50, 107, 0, 0)}; // (24,12)
        vecs[7] = '{1'b1, 1'b0,  72, mk(40, 55, 0, 7, 50, 107, 0, 0)}; // (96,12)
        vecs[8] = '{1'b0, 1'b1, 518, mk(40, 55, 0, 7, 40,   0, 0, 0)}; // (96,530)

        // Reset state
        rst = 1'b0;
        step_check(2, mk(48, 48, 0, 0, 48, 0, 0, 0));
        rst = 1'b1;

        foreach (vecs[i]) begin
            en_delta = vecs[i].ed;
            en_dwu   = vecs[i].ew;
            step_check(vecs[i].n, vecs[i].e);
        end

        // Delta sweep completion at 672 enabled cycles
        en_delta = 1'b1; en_dwu = 1'b0;
        step_check(575, mk( 7, 6, 7, 6, 40, 0, 0, 0)); // 671
        step_check(1,   mk(48, 7, 0, 7, 40, 0, 1, 0)); // 672
        step_check(1,   mk(48, 7, 0, 7, 40, 0, 0, 0)); // 673
        chk("delta_pulse_count", delta_pulses, 1);

        // dwu sweep completion at 7*53*10 = 3710 enabled cycles
        en_delta = 1'b0; en_dwu = 1'b1;
        step_check(3179, mk(48, 7, 0, 7,  7, 423, 0, 0)); // 3709
        step_check(1,    mk(48, 7, 0, 7, 48,   0, 0, 1)); // 3710
        step_check(1,    mk(48, 7, 0, 7, 49,  53, 0, 0)); // 3711
        chk("dwu_pulse_count", dwu_pulses, 1);

        // Move delta mid-period, then dwu into its flush gap
        en_delta = 1'b1; en_dwu = 1'b0;
        step_check(5, mk(48, 7, 0, 7, 49, 53, 0, 0));     // delta 678
        en_delta = 1'b0; en_dwu = 1'b1;
        step_check(7, mk(48, 7, 0, 7, 55, 371, 0, 0));    // dwu 3718, gap

        // Mid-sweep reset with both enables high
        en_delta = 1'b1; en_dwu = 1'b1; rst = 1'b0;
        step_check(1, mk(48, 48, 0, 0, 48, 0, 0, 0));
        rst = 1'b1;
        step_check(1,  mk(48, 48, 0, 0, 49,  53, 0, 0));  // (1,1)
        step_check(11, mk(49, 48, 1, 0, 50, 107, 0, 0));  // (12,12)
        chk("delta_pulse_total", delta_pulses, 1);
        chk("dwu_pulse_total",   dwu_pulses, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
